// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1-style UART receiver with mid-bit sampling,
// framing-error and BREAK reporting, one-cycle result strobes.
module uart_rx_core #(
  parameter int CLOCK_FREQ   = 25000000,
  parameter int BIT_RATE     = 115200,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    rx,
  input  logic                    rx_en,
  output logic [PAYLOAD_BITS-1:0] rx_data,
  output logic                    rx_valid,
  output logic                    rx_break,
  output logic                    frame_error,
  output logic                    busy
);

  localparam int C  = CLOCK_FREQ / BIT_RATE;
  localparam int H  = C / 2;
  localparam int CW = $clog2(C);
  localparam int BW = $clog2(PAYLOAD_BITS + 1);

  localparam logic [CW-1:0] C_LAST = CW'(C - 1);
  localparam logic [CW-1:0] H_LAST = CW'(H - 1);
  localparam logic [BW-1:0] B_LAST = BW'(PAYLOAD_BITS - 1);

  generate
    if (C < 4) begin : g_bad_rate
      $error("uart_rx_core: CLOCK_FREQ/BIT_RATE below 4");
    end
    if (PAYLOAD_BITS < 5 || PAYLOAD_BITS > 8) begin : g_bad_width
      $error("uart_rx_core: PAYLOAD_BITS outside 5..8");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t state, state_d;

  logic [1:0]              sync_q;
  logic                    rs;
  logic [CW-1:0]           cnt, cnt_d;
  logic [BW-1:0]           bidx, bidx_d;
  logic [PAYLOAD_BITS-1:0] shift, shift_d;
  logic [PAYLOAD_BITS-1:0] data_d;
  logic                    valid_d, brk_d, ferr_d;

  assign rs   = sync_q[1];
  assign busy = (state != IDLE);

  // two-flop synchroniser for the asynchronous rx line, idles high
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], rx};
  end

  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_d;
  end

  // next-state, counters, shifter and result strobes
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    bidx_d  = bidx;
    shift_d = shift;
    data_d  = rx_data;
    valid_d = 1'b0;
    brk_d   = 1'b0;
    ferr_d  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rs && rx_en) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt == H_LAST) begin
          if (rs) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            cnt_d   = '0;
            bidx_d  = '0;
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == C_LAST) begin
          cnt_d   = '0;
          shift_d = {rs, shift[PAYLOAD_BITS-1:1]};
          bidx_d  = bidx + BW'(1);
          if (bidx == B_LAST) state_d = STOP;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      STOP: begin
        if (cnt == C_LAST) begin
          if (rs) begin
            data_d  = shift;
            valid_d = 1'b1;
            state_d = IDLE;
          end else if (shift == '0) begin
            brk_d   = 1'b1;
            state_d = WAIT_HIGH;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      WAIT_HIGH: begin
        if (rs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // datapath registers and registered output pulses
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt         <= '0;
      bidx        <= '0;
      shift       <= '1;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_break    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      cnt         <= cnt_d;
      bidx        <= bidx_d;
      shift       <= shift_d;
      rx_data     <= data_d;
      rx_valid    <= valid_d;
      rx_break    <= brk_d;
      frame_error <= ferr_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: random and directed frames against a frame-level
// reference model, scoreboard monitor checks every result pulse.
module tb_uart_rx_core;

  localparam int CLOCK_FREQ = 25000000;
  localparam int BIT_RATE   = 115200;
  localparam int PB         = 8;
  localparam int C          = CLOCK_FREQ / BIT_RATE;
  localparam int H          = C / 2;
  localparam int LAT        = 2 + H + (PB + 1) * C;

  localparam int EV_VALID = 0;
  localparam int EV_BREAK = 1;
  localparam int EV_FERR  = 2;

  typedef struct {
    int          kind;
    logic [7:0]  data;
    int          t0;
  } exp_t;

  logic          clk;
  logic          resetn;
  logic          rx;
  logic          rx_en;
  logic [PB-1:0] rx_data;
  logic          rx_valid;
  logic          rx_break;
  logic          frame_error;
  logic          busy;

  exp_t       sbq[$];
  logic [7:0] last_good;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  uart_rx_core #(
    .CLOCK_FREQ  (CLOCK_FREQ),
    .BIT_RATE    (BIT_RATE),
    .PAYLOAD_BITS(PB)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .rx         (rx),
    .rx_en      (rx_en),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_break   (rx_break),
    .frame_error(frame_error),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // frame-level model: what a frame with this payload and stop bit yields
  function automatic void expect_frame(input logic [7:0] d, input logic stop);
    exp_t e;
    e.t0 = cyc;
    if (stop) begin
      e.kind    = EV_VALID;
      e.data    = d;
      last_good = d;
    end else begin
      e.kind = (d == 8'h00) ? EV_BREAK : EV_FERR;
      e.data = last_good;
    end
    sbq.push_back(e);
  endfunction

  task automatic bits(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input bit track, input bit drop_en);
    if (track) expect_frame(d, stop);
    bits(1'b0, C);
    if (drop_en) rx_en = 1'b0;
    for (int i = 0; i < PB; i++) bits(d[i], C);
    bits(stop, C);
    rx = 1'b1;
  endtask

  // monitor: every result pulse must match the oldest expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    int   kind;
    int   want;
    if (resetn && (rx_valid || rx_break || frame_error)) begin
      check("pulse_exclusive",
            $countones({rx_valid, rx_break, frame_error}), 1);
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: got v=%0b b=%0b f=%0b expected none",
                 rx_valid, rx_break, frame_error);
      end else begin
        e    = sbq.pop_front();
        kind = rx_valid ? EV_VALID : (rx_break ? EV_BREAK : EV_FERR);
        check("pulse_kind", kind, e.kind);
        check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
        want = e.t0 + 1 + LAT;
        n_cmp++;
        if (cyc < want - 2 || cyc > want + 2) begin
          n_bad++;
          $display("FAIL latency: got cycle %0d expected %0d +/-2", cyc, want);
        end
      end
    end
  end

  initial begin : stim
    int t0;
    int gap;
    logic [7:0] d;
    logic stop;

    resetn    = 1'b0;
    rx        = 1'b1;
    rx_en     = 1'b1;
    last_good = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_rx_data", {24'd0, rx_data}, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_break", rx_break, 0);
    check("rst_ferr", frame_error, 0);
    check("rst_busy", busy, 0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    check("t1_busy_after", busy, 0);
    bits(1'b1, C);

    send_frame(8'h00, 1'b1, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b1, 1'b0);
    send_frame(8'h81, 1'b1, 1'b1, 1'b0);
    bits(1'b1, C);

    t0 = cyc;
    bits(1'b0, 4);
    check("t3_busy_high", busy, 1);
    bits(1'b0, 46);
    rx = 1'b1;
    for (int k = 0; k < H + 10; k++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check("t3_busy_low_in_time", ((cyc - t0) <= H + 4) && !busy, 1);
    bits(1'b1, C);

    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    bits(1'b1, C);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    bits(1'b1, C);

    expect_frame(8'h00, 1'b0);
    bits(1'b0, 12 * C);
    bits(1'b1, C);
    send_frame(8'h55, 1'b1, 1'b1, 1'b0);
    bits(1'b1, C);

    bits(1'b0, C);
    bits(1'b1, C);
    bits(1'b0, C);
    bits(1'b1, C / 2);
    resetn = 1'b0;
    #1;
    check("t6_rst_rx_data", {24'd0, rx_data}, 0);
    check("t6_rst_pulses", {rx_valid, rx_break, frame_error}, 0);
    check("t6_rst_busy", busy, 0);
    last_good = 8'h00;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    bits(1'b1, C);
    send_frame(8'hC3, 1'b1, 1'b1, 1'b0);
    bits(1'b1, C);

    send_frame(8'h96, 1'b1, 1'b1, 1'b1);
    bits(1'b1, C);
    send_frame(8'h3E, 1'b1, 1'b0, 1'b0);
    bits(1'b1, C);
    check("en_off_idle", busy, 0);
    rx_en = 1'b1;

    for (int n = 0; n < 12; n++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 5) != 0);
      send_frame(d, stop, 1'b1, 1'b0);
      gap  = stop ? $urandom_range(0, 1) * C : C + $urandom_range(0, C);
      bits(1'b1, gap);
    end

    bits(1'b1, 2 * C);
    check("scoreboard_empty", sbq.size(), 0);
    check("final_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
